soc_system_sysid_ext: RTL and testbench
=======================================

Name: soc_system_sysid_ext

Overview:
Parametrised system-ID and housekeeping slave on the HPS lightweight bus, the successor to the two-word system ID block. It exposes a build ID and a build timestamp, plus:
- a capability word
- a 64-bit free-running uptime counter with a coherent high-word snapshot
- a software scratch register
- NUM_USER_WORDS fabric-supplied status words

Reads are pipelined with a fixed, parametrised latency and a readdatavalid handshake.

Parameters:
- SYSID, 32'h00C0FFEE, build ID returned at word 0.
- TIMESTAMP, 32'd0, build time (Unix seconds) returned at word 1.
- NUM_USER_WORDS, 2, number of 32-bit user status inputs, range 0..8.
- READ_LATENCY, 1, cycles from read acceptance to readdatavalid, range 1..3.
- ADDR_W, 4, word-address width; must cover 6+NUM_USER_WORDS words.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous, active-low.
- address  in  ADDR_W  word address.
- read  in  1  read request, accepted every cycle (no waitrequest).
- write  in  1  write request.
- writedata  in  32  write data.
- byteenable  in  4  byte lanes for write.
- user_words  in  max(1,NUM_USER_WORDS)*32  user status, word k at bits [32k+31:32k]; must be synchronous to clock.
- readdata  out  32  read data, valid when readdatavalid=1.
- readdatavalid  out  1  one-cycle pulse per accepted read.

Behaviour:
- One clock; reset is asynchronous and active-low (clock, reset_n). Assertion clears all state immediately.
- Reset values:
  - readdata=0, readdatavalid=0.
  - uptime=0, shadow_hi=0, scratch=0.
  - read pipeline is flushed.
  - Reads in flight at reset are dropped; no readdatavalid is produced for them.
- Register map (word addresses):
  - 0 SYSID (RO)
  - 1 TIMESTAMP (RO)
  - 2 UPTIME_LO (RO, snapshot trigger)
  - 3 UPTIME_HI (RO, returns shadow_hi)
  - 4 SCRATCH (RW)
  - 5 CAP (RO)
  - 6..6+NUM_USER_WORDS-1 USER[k] (RO)
  - All other addresses read 32'h0.
- CAP = {8'h02 (block version), 8'(NUM_USER_WORDS), 8'(READ_LATENCY), 8'h00}.
- Uptime counter:
  - 64-bit, increments by 1 every clock from the first cycle after reset deassertion.
  - Wraps from 2^64-1 to 0 with no flag.
- Snapshot:
  - A read accepted at address 2 in cycle T returns uptime[31:0] as sampled in cycle T.
  - The same cycle loads shadow_hi <= uptime[63:32] from cycle T.
  - A read of address 3 returns shadow_hi, unchanged until the next address-2 read.
- Read path:
  - A read is accepted in any cycle with read=1 and write=0.
  - Data is selected from the state in the acceptance cycle.
  - readdata/readdatavalid appear exactly READ_LATENCY cycles later.
  - Fully pipelined: back-to-back reads give back-to-back valid pulses, in order.
  - readdata holds its last value when readdatavalid=0.
- Write path:
  - Only address 4 is writable. Each byte lane i with byteenable[i]=1 updates scratch[8i+7:8i] at the clock edge.
  - Writes to any other address are ignored without error.
  - A read of address 4 accepted in the cycle after a write returns the new value.
- read=1 and write=1 in the same cycle (a bus protocol violation): the write is performed, the read is ignored, and no readdatavalid is produced.
- user_words are sampled in the read acceptance cycle with no extra synchronisation.
- NUM_USER_WORDS=0: the user_words port is 32 bits wide and unused; addresses 6+ read 0.

Decomposition:
- Package sysid_pkg:
  - register offset constants (ADDR_SYSID..ADDR_USER_BASE)
  - CAP_VERSION=8'h02
  - UNMAPPED_VALUE=32'h0
- One sub-module, soc_system_sysid_rdpipe: a READ_LATENCY-deep valid/data shift pipeline with asynchronous reset.
- Register map decode, uptime counter, shadow and scratch stay in the top level.

Test Plan:
- Reset release, READ_LATENCY=2; read addr 0, 1, 5 in consecutive cycles -> three consecutive valid pulses starting 2 cycles after the first read, with data 32'h00C0FFEE, 32'd0, 32'h02020200.
- Force uptime to 64'h00000001_FFFFFFFE; read addr 2, then two idle cycles, then read addr 3 -> returns 32'hFFFFFFFE, then 32'h00000001 (not 2), although the counter carried in between.
- Write 32'hA5A5A5A5 to addr 4 with byteenable 4'b1111, then write 32'h00000000 with byteenable 4'b0101 -> read addr 4 returns 32'hA500A500. Write to addr 0 -> addr 0 still reads SYSID.
- read and write asserted together at addr 4 with data 32'h12345678 -> no readdatavalid; a following read returns 32'h12345678.
- NUM_USER_WORDS=2, user_words={32'hBEEF0001,32'hCAFE0000}; read addr 6, 7, 8, 15 -> 32'hCAFE0000, 32'hBEEF0001, 32'h0, 32'h0.
- Assert reset_n=0 with two reads in flight (READ_LATENCY=3) -> readdatavalid drops immediately, no pulses after release; uptime restarts at 0 and scratch reads 0.

Source files
------------

// File: rtl/sysid_pkg.sv
// Shared constants and payload types for the extended system-ID slave.
package sysid_pkg;

  localparam int unsigned DATA_W = 32;

  // Word offsets of the register map
  localparam int unsigned ADDR_SYSID     = 0;
  localparam int unsigned ADDR_TIMESTAMP = 1;
  localparam int unsigned ADDR_UPTIME_LO = 2;
  localparam int unsigned ADDR_UPTIME_HI = 3;
  localparam int unsigned ADDR_SCRATCH   = 4;
  localparam int unsigned ADDR_CAP       = 5;
  localparam int unsigned ADDR_USER_BASE = 6;

  localparam logic [7:0]        CAP_VERSION    = 8'h02;
  localparam logic [DATA_W-1:0] UNMAPPED_VALUE = 32'h0;

  // One read-pipeline stage: valid flag plus the data it carries
  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
  } rd_beat_t;

endpackage

// File: rtl/soc_system_sysid_rdpipe.sv
// Fixed-latency read return pipeline; data of each stage holds when no beat passes.
module soc_system_sysid_rdpipe
  import sysid_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  rd_beat_t stage [LATENCY];

  // Shift valid every cycle; move data only alongside a valid beat
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0].valid <= in_valid;
      if (in_valid) begin
        stage[0].data <= in_data;
      end
      for (int unsigned i = 1; i < LATENCY; i++) begin
        stage[i].valid <= stage[i-1].valid;
        if (stage[i-1].valid) begin
          stage[i].data <= stage[i-1].data;
        end
      end
    end
  end

  assign out_valid = stage[LATENCY-1].valid;
  assign out_data  = stage[LATENCY-1].data;

endmodule

// File: rtl/soc_system_sysid_ext.sv
// System-ID / housekeeping slave: IDs, capability, uptime with snapshot, scratch, user status.
module soc_system_sysid_ext
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSID          = 32'h00C0FFEE,
  parameter logic [31:0] TIMESTAMP      = 32'd0,
  parameter int unsigned NUM_USER_WORDS = 2,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned ADDR_W         = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  input  logic [3:0]          byteenable,
  input  logic [((NUM_USER_WORDS == 0) ? 32 : NUM_USER_WORDS*32)-1:0] user_words,
  output logic [31:0]         readdata,
  output logic                readdatavalid
);

  logic [63:0]       uptime;
  logic [31:0]       shadow_hi;
  logic [31:0]       scratch;
  logic              rd_accept_c;
  logic              wr_scratch_c;
  logic              snap_c;
  logic [31:0]       word_c;
  logic [DATA_W-1:0] rd_data_c;

  // A simultaneous write wins; the colliding read is dropped
  assign rd_accept_c  = read & ~write;
  assign word_c       = 32'(address);
  assign wr_scratch_c = write & (word_c == ADDR_SCRATCH);
  assign snap_c       = rd_accept_c & (word_c == ADDR_UPTIME_LO);

  // Free-running 64-bit uptime, wraps silently
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime <= '0;
    end else begin
      uptime <= uptime + 64'd1;
    end
  end

  // Capture the high word alongside a low-word read so the pair is coherent
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_hi <= '0;
    end else if (snap_c) begin
      shadow_hi <= uptime[63:32];
    end
  end

  // Byte-lane masked scratch register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch <= '0;
    end else if (wr_scratch_c) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteenable[i]) begin
          scratch[8*i +: 8] <= writedata[8*i +: 8];
        end
      end
    end
  end

  // Register map decode using state in the acceptance cycle
  always_comb begin
    rd_data_c = UNMAPPED_VALUE;
    case (word_c)
      ADDR_SYSID:     rd_data_c = SYSID;
      ADDR_TIMESTAMP: rd_data_c = TIMESTAMP;
      ADDR_UPTIME_LO: rd_data_c = uptime[31:0];
      ADDR_UPTIME_HI: rd_data_c = shadow_hi;
      ADDR_SCRATCH:   rd_data_c = scratch;
      ADDR_CAP:       rd_data_c = {CAP_VERSION, 8'(NUM_USER_WORDS), 8'(READ_LATENCY), 8'h00};
      default: begin
        for (int unsigned k = 0; k < NUM_USER_WORDS; k++) begin
          if (word_c == ADDR_USER_BASE + k) begin
            rd_data_c = user_words[32*k +: 32];
          end
        end
      end
    endcase
  end

  soc_system_sysid_rdpipe #(
    .LATENCY (READ_LATENCY)
  ) u_rdpipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (rd_accept_c),
    .in_data   (rd_data_c),
    .out_valid (readdatavalid),
    .out_data  (readdata)
  );

endmodule

// File: tb/tb_soc_system_sysid_ext.sv
// Scoreboard bench for the system-ID slave, driving latency-2 and latency-3 instances in lockstep.
module tb_soc_system_sysid_ext;

  localparam logic [31:0] SYSID_V = 32'h00C0FFEE;
  localparam logic [31:0] CAP2    = 32'h02020200;
  localparam logic [31:0] CAP3    = 32'h02020300;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [63:0] user_words;
  logic [31:0] readdata2, readdata3;
  logic        readdatavalid2, readdatavalid3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int base   = 0;
  logic [31:0] scr_model = 32'h0;

  typedef struct {
    logic [31:0] d2;
    logic [31:0] d3;
    int          acc;
    string       tag;
  } exp_t;

  exp_t q2[$];
  exp_t q3[$];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  soc_system_sysid_ext #(
    .NUM_USER_WORDS (2),
    .READ_LATENCY   (2),
    .ADDR_W         (4)
  ) dut2 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .user_words    (user_words),
    .readdata      (readdata2),
    .readdatavalid (readdatavalid2)
  );

  soc_system_sysid_ext #(
    .NUM_USER_WORDS (2),
    .READ_LATENCY   (3),
    .ADDR_W         (4)
  ) dut3 (
    .clock         (clock),
    .reset_n       (reset_n),
    .address       (address),
    .read          (read),
    .write         (write),
    .writedata     (writedata),
    .byteenable    (byteenable),
    .user_words    (user_words),
    .readdata      (readdata3),
    .readdatavalid (readdatavalid3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the read is accepted at the next rising edge
  task automatic do_read(input logic [3:0] a, input logic [31:0] e2, input logic [31:0] e3,
                         input string tag);
    exp_t e;
    read    = 1'b1;
    write   = 1'b0;
    address = a;
    e.d2  = e2;
    e.d3  = e3;
    e.acc = cyc + 1;
    e.tag = tag;
    q2.push_back(e);
    q3.push_back(e);
    @(negedge clock);
  endtask

  task automatic do_read1(input logic [3:0] a, input logic [31:0] e, input string tag);
    do_read(a, e, e, tag);
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be,
                          input logic also_read);
    read       = also_read;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    byteenable = be;
    if (a == 4'd4) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) scr_model[8*i +: 8] = d[8*i +: 8];
      end
    end
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    read  = 1'b0;
    write = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Latency-2 return monitor
  always @(negedge clock) begin
    exp_t e;
    if (readdatavalid2) begin
      if (q2.size() == 0) begin
        check_eq("spurious_valid_rl2", 32'(readdatavalid2), 32'd0);
      end else begin
        e = q2.pop_front();
        check_eq({e.tag, "_rl2"}, readdata2, e.d2);
        check_eq({e.tag, "_lat_rl2"}, 32'(cyc), 32'(e.acc + 1));
      end
    end
  end

  // Latency-3 return monitor
  always @(negedge clock) begin
    exp_t e;
    if (readdatavalid3) begin
      if (q3.size() == 0) begin
        check_eq("spurious_valid_rl3", 32'(readdatavalid3), 32'd0);
      end else begin
        e = q3.pop_front();
        check_eq({e.tag, "_rl3"}, readdata3, e.d3);
        check_eq({e.tag, "_lat_rl3"}, 32'(cyc), 32'(e.acc + 2));
      end
    end
  end

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    read       = 1'b0;
    write      = 1'b0;
    writedata  = '0;
    byteenable = '0;
    user_words = {32'hBEEF0001, 32'hCAFE0000};

    repeat (3) @(negedge clock);
    check_eq("reset_rdata_rl2", readdata2, 32'h0);
    check_eq("reset_valid_rl2", 32'(readdatavalid2), 32'h0);
    check_eq("reset_rdata_rl3", readdata3, 32'h0);
    check_eq("reset_valid_rl3", 32'(readdatavalid3), 32'h0);
    reset_n = 1'b1;
    base    = cyc;

    // Identity words back-to-back
    do_read1(4'd0, SYSID_V, "sysid");
    do_read1(4'd1, 32'd0, "timestamp");
    do_read(4'd5, CAP2, CAP3, "cap");
    idle(5);

    // Uptime counts from the first cycle after release
    do_read1(4'd2, 32'(cyc - base), "uptime_lo_start");
    do_read1(4'd3, 32'h0, "uptime_hi_start");
    idle(4);

    // Byte-lane scratch writes and a write to a read-only word
    do_write(4'd4, 32'hA5A5A5A5, 4'b1111, 1'b0);
    do_write(4'd4, 32'h00000000, 4'b0101, 1'b0);
    do_read1(4'd4, scr_model, "scratch_be");
    do_write(4'd0, 32'hFFFFFFFF, 4'b1111, 1'b0);
    do_read1(4'd0, SYSID_V, "sysid_ro");
    idle(5);

    // Read+write collision: write lands, read is dropped
    do_write(4'd4, 32'h12345678, 4'b1111, 1'b1);
    do_read1(4'd4, scr_model, "scratch_collide");
    idle(5);

    // User words and unmapped addresses
    do_read1(4'd6, 32'hCAFE0000, "user0");
    do_read1(4'd7, 32'hBEEF0001, "user1");
    do_read1(4'd8, 32'h0, "unmapped8");
    do_read1(4'd15, 32'h0, "unmapped15");
    idle(5);

    // Coherent snapshot across a carry into the high word
    force dut2.uptime = 64'h00000001_FFFFFFFE;
    force dut3.uptime = 64'h00000001_FFFFFFFE;
    do_read1(4'd2, 32'hFFFFFFFE, "snap_lo");
    release dut2.uptime;
    release dut3.uptime;
    idle(2);
    do_read1(4'd3, 32'h00000001, "snap_hi");
    idle(5);

    // Reset with two reads in flight in the latency-3 instance
    do_read1(4'd4, scr_model, "inflight_a");
    do_read1(4'd0, SYSID_V, "inflight_b");
    read    = 1'b0;
    reset_n = 1'b0;
    #1;
    check_eq("rst_valid_rl2", 32'(readdatavalid2), 32'h0);
    check_eq("rst_valid_rl3", 32'(readdatavalid3), 32'h0);
    check_eq("rst_rdata_rl3", readdata3, 32'h0);
    q2.delete();
    q3.delete();
    scr_model = 32'h0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    base    = cyc;
    idle(6);

    do_read1(4'd3, 32'h0, "post_rst_hi");
    do_read1(4'd2, 32'(cyc - base), "post_rst_uptime");
    do_read1(4'd4, 32'h0, "post_rst_scratch");
    idle(6);

    check_eq("drain_rl2", 32'(q2.size()), 32'h0);
    check_eq("drain_rl3", 32'(q3.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
